// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data load/store channels.
// One transaction is in flight at a time: a write retires at request ack, a read at response ack.
module mem_port_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr,
    input  logic        inst_req_valid,
    output logic        inst_req_ack,
    output logic [31:0] inst_rdata,
    output logic        inst_rdata_valid,
    input  logic        inst_rdata_ack,
    input  logic [31:0] data_addr,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_strb,
    output logic        data_req_ack,
    output logic [31:0] data_rdata,
    output logic        data_rdata_valid,
    input  logic        data_rdata_ack,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strb,
    input  logic        mem_req_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    output logic        mem_rdata_ack,
    output logic        grant_data,
    output logic        timeout_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_strb;
    logic             r_read;
    logic             r_write;
    logic             r_grant_data;   // doubles as last_grant: 1 = data channel
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    logic w_pend_i;
    logic w_pend_d;
    logic w_win_data;
    logic w_in_req;
    logic w_in_resp;
    logic w_busy;
    logic w_rd_ack;
    logic w_cnt_hit;

    assign w_pend_i  = inst_req_valid;
    assign w_pend_d  = data_read | data_write;
    // Under contention round-robin hands the port to the channel not granted last time.
    assign w_win_data = w_pend_d & (~w_pend_i | (PRIO_MODE != 0) | ~r_grant_data);
    assign w_in_req  = (r_state == ST_REQ);
    assign w_in_resp = (r_state == ST_RESP);
    assign w_busy    = w_in_req | w_in_resp;
    assign w_rd_ack  = r_grant_data ? data_rdata_ack : inst_rdata_ack;

    generate
        if (TIMEOUT != 0) begin : g_tmo
            assign w_cnt_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign w_cnt_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_strb       <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_grant_data <= 1'b0;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pend_i | w_pend_d) begin
                        r_state      <= ST_REQ;
                        r_grant_data <= w_win_data;
                        r_cnt        <= '0;
                        if (w_win_data) begin
                            // A simultaneous read+write request is serviced as a write.
                            r_addr  <= data_addr;
                            r_write <= data_write;
                            r_read  <= ~data_write;
                            r_wdata <= data_wdata;
                            r_strb  <= data_strb;
                        end else begin
                            r_addr  <= inst_addr;
                            r_write <= 1'b0;
                            r_read  <= 1'b1;
                            r_wdata <= '0;
                            r_strb  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ack) begin
                        r_state <= r_write ? ST_IDLE : ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rdata_valid & w_rd_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_busy) begin
                if (!(&r_cnt)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_cnt_hit) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign mem_addr   = w_in_req ? r_addr  : '0;
    assign mem_wdata  = w_in_req ? r_wdata : '0;
    assign mem_strb   = w_in_req ? r_strb  : '0;
    assign mem_read   = w_in_req & r_read;
    assign mem_write  = w_in_req & r_write;

    assign inst_req_ack     = w_in_req & ~r_grant_data & mem_req_ack;
    assign data_req_ack     = w_in_req &  r_grant_data & mem_req_ack;
    assign inst_rdata       = (w_in_resp & ~r_grant_data) ? mem_rdata : '0;
    assign data_rdata       = (w_in_resp &  r_grant_data) ? mem_rdata : '0;
    assign inst_rdata_valid = w_in_resp & ~r_grant_data & mem_rdata_valid;
    assign data_rdata_valid = w_in_resp &  r_grant_data & mem_rdata_valid;
    assign mem_rdata_ack    = w_in_resp & w_rd_ack;

    assign grant_data  = r_grant_data;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model, run on a round-robin and a fixed-priority instance.
module tb_mem_port_arbiter;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] inst_addr [2];
    logic        inst_req_valid [2];
    logic        inst_req_ack [2];
    logic [31:0] inst_rdata [2];
    logic        inst_rdata_valid [2];
    logic        inst_rdata_ack [2];
    logic [31:0] data_addr [2];
    logic        data_read [2];
    logic        data_write [2];
    logic [31:0] data_wdata [2];
    logic [3:0]  data_strb [2];
    logic        data_req_ack [2];
    logic [31:0] data_rdata [2];
    logic        data_rdata_valid [2];
    logic        data_rdata_ack [2];
    logic [31:0] mem_addr [2];
    logic        mem_read [2];
    logic        mem_write [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_strb [2];
    logic        mem_req_ack [2];
    logic [31:0] mem_rdata [2];
    logic        mem_rdata_valid [2];
    logic        mem_rdata_ack [2];
    logic        grant_data [2];
    logic        timeout_err [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            mem_port_arbiter #(.PRIO_MODE(gi), .TIMEOUT(TMO), .CNT_W(16)) u_dut (
                .clk(clk), .rst(rst),
                .inst_addr(inst_addr[gi]), .inst_req_valid(inst_req_valid[gi]),
                .inst_req_ack(inst_req_ack[gi]), .inst_rdata(inst_rdata[gi]),
                .inst_rdata_valid(inst_rdata_valid[gi]), .inst_rdata_ack(inst_rdata_ack[gi]),
                .data_addr(data_addr[gi]), .data_read(data_read[gi]), .data_write(data_write[gi]),
                .data_wdata(data_wdata[gi]), .data_strb(data_strb[gi]),
                .data_req_ack(data_req_ack[gi]), .data_rdata(data_rdata[gi]),
                .data_rdata_valid(data_rdata_valid[gi]), .data_rdata_ack(data_rdata_ack[gi]),
                .mem_addr(mem_addr[gi]), .mem_read(mem_read[gi]), .mem_write(mem_write[gi]),
                .mem_wdata(mem_wdata[gi]), .mem_strb(mem_strb[gi]), .mem_req_ack(mem_req_ack[gi]),
                .mem_rdata(mem_rdata[gi]), .mem_rdata_valid(mem_rdata_valid[gi]),
                .mem_rdata_ack(mem_rdata_ack[gi]), .grant_data(grant_data[gi]),
                .timeout_err(timeout_err[gi])
            );
        end
    endgenerate

    int n_cmp = 0;
    int n_err = 0;
    int u;

    // Reference model: who owns the port, whether its read data is awaited, and the
    // transaction captured at grant time.
    int          m_owner;     // -1 none, 0 inst, 1 data
    bit          m_resp;
    bit          m_write;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_strb;
    bit          m_last_data;
    int          m_busy;
    bit          m_err;

    logic        s_iack, s_dack, s_irv, s_drv, s_mread, s_mwrite, s_terr, s_gd, s_mrack;
    logic [31:0] s_irdata, s_drdata, s_maddr, s_mwdata;
    logic [3:0]  s_mstrb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s (inst %0d): observed %h expected %h", tag, u, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_resp = 0; m_write = 0; m_addr = '0; m_wdata = '0; m_strb = '0;
        m_last_data = 0; m_busy = 0; m_err = 0;
    endtask

    task automatic zero_inputs();
        for (int k = 0; k < 2; k++) begin
            inst_addr[k] = '0; inst_req_valid[k] = 0; inst_rdata_ack[k] = 0;
            data_addr[k] = '0; data_read[k] = 0; data_write[k] = 0; data_wdata[k] = '0;
            data_strb[k] = '0; data_rdata_ack[k] = 0; mem_req_ack[k] = 0;
            mem_rdata[k] = '0; mem_rdata_valid[k] = 0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_inst_req_ack"}, inst_req_ack[u], 0);
        chk({tag, "_inst_rdata"}, inst_rdata[u], 0);
        chk({tag, "_inst_rdata_valid"}, inst_rdata_valid[u], 0);
        chk({tag, "_data_req_ack"}, data_req_ack[u], 0);
        chk({tag, "_data_rdata"}, data_rdata[u], 0);
        chk({tag, "_data_rdata_valid"}, data_rdata_valid[u], 0);
        chk({tag, "_mem_addr"}, mem_addr[u], 0);
        chk({tag, "_mem_read"}, mem_read[u], 0);
        chk({tag, "_mem_write"}, mem_write[u], 0);
        chk({tag, "_mem_wdata"}, mem_wdata[u], 0);
        chk({tag, "_mem_strb"}, {28'd0, mem_strb[u]}, 0);
        chk({tag, "_mem_rdata_ack"}, mem_rdata_ack[u], 0);
        chk({tag, "_grant_data"}, grant_data[u], 0);
        chk({tag, "_timeout_err"}, timeout_err[u], 0);
    endtask

    task automatic do_reset();
        zero_inputs();
        rst = 0;
        @(posedge clk); #1;
        chk_zero("reset");
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        model_reset();
    endtask

    // One clock: settle, sample and compare against the model, advance the model, clock.
    task automatic cycle();
        logic        own_req, own_resp, own_d, rack;
        int          pi, pd;
        bit          win_d;
        #1;
        s_iack = inst_req_ack[u]; s_dack = data_req_ack[u];
        s_irv = inst_rdata_valid[u]; s_drv = data_rdata_valid[u];
        s_irdata = inst_rdata[u]; s_drdata = data_rdata[u];
        s_maddr = mem_addr[u]; s_mread = mem_read[u]; s_mwrite = mem_write[u];
        s_mwdata = mem_wdata[u]; s_mstrb = mem_strb[u]; s_mrack = mem_rdata_ack[u];
        s_terr = timeout_err[u]; s_gd = grant_data[u];

        own_req  = (m_owner >= 0) && !m_resp;
        own_resp = (m_owner >= 0) && m_resp;
        own_d    = (m_owner == 1);
        rack     = own_d ? data_rdata_ack[u] : inst_rdata_ack[u];
        chk("mem_addr", s_maddr, own_req ? m_addr : 32'd0);
        chk("mem_read", s_mread, own_req && !m_write);
        chk("mem_write", s_mwrite, own_req && m_write);
        chk("mem_wdata", s_mwdata, own_req ? m_wdata : 32'd0);
        chk("mem_strb", {28'd0, s_mstrb}, own_req ? {28'd0, m_strb} : 32'd0);
        chk("inst_req_ack", s_iack, own_req && !own_d && mem_req_ack[u]);
        chk("data_req_ack", s_dack, own_req && own_d && mem_req_ack[u]);
        chk("inst_rdata", s_irdata, (own_resp && !own_d) ? mem_rdata[u] : 32'd0);
        chk("data_rdata", s_drdata, (own_resp && own_d) ? mem_rdata[u] : 32'd0);
        chk("inst_rdata_valid", s_irv, own_resp && !own_d && mem_rdata_valid[u]);
        chk("data_rdata_valid", s_drv, own_resp && own_d && mem_rdata_valid[u]);
        chk("mem_rdata_ack", s_mrack, own_resp && rack);
        chk("grant_data", s_gd, m_last_data);
        chk("timeout_err", s_terr, m_err);

        if (m_owner < 0) begin
            pi = inst_req_valid[u];
            pd = data_read[u] | data_write[u];
            if (pi != 0 || pd != 0) begin
                win_d = (pd != 0) && (pi == 0 || u == 1 || !m_last_data);
                if (win_d) begin
                    m_write = data_write[u]; m_addr = data_addr[u];
                    m_wdata = data_wdata[u]; m_strb = data_strb[u];
                end else begin
                    m_write = 0; m_addr = inst_addr[u]; m_wdata = '0; m_strb = '0;
                end
                m_owner = win_d ? 1 : 0;
                m_last_data = win_d;
                m_resp = 0;
                m_busy = 0;
            end
        end else begin
            m_busy++;
            if (m_busy >= TMO) m_err = 1;
            if (!m_resp) begin
                if (mem_req_ack[u]) begin
                    if (m_write) m_owner = -1;
                    else m_resp = 1;
                end
            end else if (mem_rdata_valid[u] && rack) begin
                m_owner = -1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int got, cyc, k;
        bit  done, exp_d;
        zero_inputs();
        model_reset();
        s_iack = 0; s_dack = 0;
        for (int uu = 0; uu < 2; uu++) begin
            u = uu;
            do_reset();

            // Single fetch with a one-cycle-late request ack.
            inst_req_valid[u] = 1; inst_addr[u] = 32'h0000_0010;
            cycle();
            cycle();
            chk("fetch_mem_read", s_mread, 1);
            chk("fetch_mem_addr", s_maddr, 32'h10);
            chk("fetch_no_early_ack", s_iack, 0);
            mem_req_ack[u] = 1;
            cycle();
            chk("fetch_req_ack", s_iack, 1);
            inst_req_valid[u] = 0; mem_req_ack[u] = 0;
            mem_rdata[u] = 32'h0050_0093; mem_rdata_valid[u] = 1; inst_rdata_ack[u] = 1;
            cycle();
            chk("fetch_rdata", s_irdata, 32'h0050_0093);
            chk("fetch_rdata_valid", s_irv, 1);
            chk("fetch_no_data_ack", s_dack, 0);
            zero_inputs();
            cycle();
            chk("fetch_back_idle", s_irv, 0);

            // Store with immediate ack: two cycles, no response phase.
            data_write[u] = 1; data_addr[u] = 32'h2000; data_wdata[u] = 32'hDEAD_BEEF;
            data_strb[u] = 4'b0011; mem_req_ack[u] = 1; mem_rdata_valid[u] = 1;
            data_rdata_ack[u] = 1;
            cycle();
            cycle();
            chk("store_mem_write", s_mwrite, 1);
            chk("store_wdata", s_mwdata, 32'hDEAD_BEEF);
            chk("store_strb", {28'd0, s_mstrb}, 32'h3);
            chk("store_addr", s_maddr, 32'h2000);
            chk("store_ack", s_dack, 1);
            data_write[u] = 0;
            cycle();
            chk("store_one_cycle", s_mwrite, 0);
            chk("store_no_resp", s_drv, 0);
            zero_inputs();
            cycle();

            // Continuous contention.
            do_reset();
            inst_req_valid[u] = 1; inst_addr[u] = 32'h100;
            data_write[u] = 1; data_addr[u] = 32'h3000; data_wdata[u] = 32'h5555_AAAA;
            data_strb[u] = 4'hF; mem_req_ack[u] = 1; mem_rdata_valid[u] = 1;
            mem_rdata[u] = 32'h1111_2222; inst_rdata_ack[u] = 1;
            got = 0; cyc = 0;
            while (got < 8 && cyc < 200) begin
                cycle(); cyc++;
                if (s_iack || s_dack) begin
                    exp_d = (u == 1) ? 1'b1 : ((got % 2) == 0);
                    chk("contention_grant_is_data", s_dack, exp_d);
                    got++;
                end
            end
            chk("contention_grant_count", got, 8);
            data_write[u] = 0;
            done = 0; cyc = 0;
            while (!done && cyc < 20) begin
                cycle(); cyc++;
                if (s_iack || s_dack) begin
                    chk("data_idle_inst_wins", s_iack, 1);
                    done = 1;
                end
            end
            chk("data_idle_grant_seen", done, 1);
            inst_req_valid[u] = 0;
            repeat (3) cycle();

            // Random traffic.
            for (int c = 0; c < 1500; c++) begin
                if (inst_req_valid[u] && s_iack) inst_req_valid[u] = 0;
                if (!inst_req_valid[u] && $urandom_range(0, 2) == 0) begin
                    inst_req_valid[u] = 1; inst_addr[u] = $urandom;
                end
                if ((data_read[u] || data_write[u]) && s_dack) begin
                    data_read[u] = 0; data_write[u] = 0;
                end
                if (!(data_read[u] || data_write[u]) && $urandom_range(0, 2) == 0) begin
                    k = $urandom_range(0, 2);
                    data_read[u] = (k != 1); data_write[u] = (k != 0);
                    data_addr[u] = $urandom; data_wdata[u] = $urandom;
                    data_strb[u] = 4'($urandom_range(0, 15));
                end
                mem_req_ack[u] = 1'($urandom_range(0, 1));
                mem_rdata_valid[u] = 1'($urandom_range(0, 1));
                mem_rdata[u] = $urandom;
                inst_rdata_ack[u] = 1'($urandom_range(0, 1));
                data_rdata_ack[u] = 1'($urandom_range(0, 1));
                cycle();
            end

            // Timeout on a stalled read, which still completes afterwards.
            do_reset();
            inst_req_valid[u] = 1; inst_addr[u] = 32'h40;
            cycle();
            for (int i = 0; i < TMO; i++) begin
                cycle();
                chk("timeout_not_yet", s_terr, 0);
            end
            cycle();
            chk("timeout_set", s_terr, 1);
            repeat (3) cycle();
            chk("timeout_sticky", s_terr, 1);
            mem_req_ack[u] = 1;
            cycle();
            chk("timeout_late_ack", s_iack, 1);
            inst_req_valid[u] = 0; mem_req_ack[u] = 0;
            mem_rdata_valid[u] = 1; mem_rdata[u] = 32'h0000_1234; inst_rdata_ack[u] = 1;
            cycle();
            chk("timeout_read_done", s_irv, 1);
            chk("timeout_read_data", s_irdata, 32'h1234);
            zero_inputs();
            cycle();
            chk("timeout_after_done", s_terr, 1);

            // Asynchronous reset while the read data is waiting to be consumed.
            do_reset();
            inst_req_valid[u] = 1; inst_addr[u] = 32'h80; mem_req_ack[u] = 1;
            cycle();
            cycle();
            inst_req_valid[u] = 0; mem_req_ack[u] = 0;
            mem_rdata_valid[u] = 1; mem_rdata[u] = 32'hCAFE_F00D; inst_rdata_ack[u] = 0;
            #2;
            chk("pre_reset_valid", inst_rdata_valid[u], 1);
            rst = 0;
            #1;
            chk_zero("mid_reset");
            zero_inputs();
            @(posedge clk); #1;
            @(negedge clk); rst = 1;
            @(posedge clk); #1;
            model_reset();
            inst_req_valid[u] = 1; inst_addr[u] = 32'h90; mem_req_ack[u] = 1;
            mem_rdata_valid[u] = 1; mem_rdata[u] = 32'h0000_0013; inst_rdata_ack[u] = 1;
            done = 0; cyc = 0;
            while (!done && cyc < 10) begin
                cycle(); cyc++;
                if (s_iack) inst_req_valid[u] = 0;
                if (s_irv) begin
                    chk("refetch_data", s_irdata, 32'h13);
                    done = 1;
                end
            end
            chk("refetch_completed", done, 1);
            zero_inputs();
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
